prog_xbar: RTL



---
 rtl/prog_xbar_pkg.sv | 32 +++
 rtl/prog_xbar_mux.sv | 26 ++
 rtl/prog_xbar.sv | 98 +++++++++
 3 files changed

// File: rtl/prog_xbar_pkg.sv
// Shared types and size helpers for the programmable crossbar.
// The chain length, counter width and config FSM state all come from here.
package prog_xbar_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    READY   = 2'd2,
    OVERRUN = 2'd3
  } state_t;

  function automatic int unsigned chain_len(input int unsigned outputs, input int unsigned sel);
    return outputs * sel;
  endfunction

  // The counter must hold CHAIN_LEN+1 so that an over-length load stays visible.
  function automatic int unsigned cnt_w(input int unsigned len);
    return $clog2(len + 2);
  endfunction

  function automatic state_t classify(input int unsigned cnt, input int unsigned len);
    if (cnt == 0)
      return IDLE;
    else if (cnt < len)
      return LOAD;
    else if (cnt == len)
      return READY;
    else
      return OVERRUN;
  endfunction

endpackage

// File: rtl/prog_xbar_mux.sv
// One select field's data mux with zeroing of out-of-range select values.
module prog_xbar_mux #(
  parameter int unsigned SEL    = 4,
  parameter int unsigned INPUTS = 16
) (
  input  logic [INPUTS-1:0] data_in,
  input  logic [SEL-1:0]    sel,
  output logic              data_out
);

  logic picked;
  logic in_range;

  always_comb begin
    picked = 1'b0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      if (32'(sel) == i)
        picked = data_in[i];
    end
  end

  // INPUTS need not be a power of two; unused select codes route a constant 0.
  assign in_range = (32'(sel) < INPUTS);
  assign data_out = picked & in_range;

endmodule

// File: rtl/prog_xbar.sv
// Programmable crossbar: OUTPUTS selectors loaded over a serial chain into a
// shadow register and copied to the active selects only on a validated commit.
module prog_xbar
  import prog_xbar_pkg::*;
#(
  parameter int unsigned SEL     = 4,
  parameter int unsigned INPUTS  = 16,
  parameter int unsigned OUTPUTS = 4,
  parameter int unsigned REG_OUT = 0
) (
  input  logic               config_clk,
  input  logic               config_rst,
  input  logic               config_in,
  input  logic               config_en,
  input  logic               config_commit,
  output logic               config_out,
  output logic               config_done,
  output logic               config_err,
  input  logic [INPUTS-1:0]  data_in,
  output logic [OUTPUTS-1:0] data_out
);

  localparam int unsigned CHAIN_LEN = chain_len(OUTPUTS, SEL);
  localparam int unsigned CNT_W     = cnt_w(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] shadow;
  logic [CHAIN_LEN-1:0] active;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     cnt_nxt;
  state_t               state;
  logic [OUTPUTS-1:0]   mux_out;

  // A commit alongside a shift is rejected, but the shift itself still counts.
  always_comb begin
    cnt_nxt = count;
    if (config_commit && config_en)
      cnt_nxt = CNT_W'(1);
    else if (config_commit)
      cnt_nxt = '0;
    else if (config_en && count != CNT_MAX)
      cnt_nxt = count + 1'b1;
  end

  always_ff @(posedge config_clk) begin
    if (config_rst) begin
      shadow      <= '0;
      active      <= '0;
      count       <= '0;
      state       <= IDLE;
      config_out  <= 1'b0;
      config_done <= 1'b0;
      config_err  <= 1'b0;
    end else begin
      count <= cnt_nxt;
      state <= classify(32'(cnt_nxt), CHAIN_LEN);
      if (config_en) begin
        shadow      <= {shadow[CHAIN_LEN-2:0], config_in};
        config_out  <= shadow[CHAIN_LEN-1];
        config_done <= 1'b0;
        config_err  <= 1'b0;
      end
      if (config_commit) begin
        if (state == READY && !config_en) begin
          active      <= shadow;
          config_done <= 1'b1;
          config_err  <= 1'b0;
        end else begin
          config_done <= 1'b0;
          config_err  <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < OUTPUTS; k++) begin : g_mux
    prog_xbar_mux #(
      .SEL    (SEL),
      .INPUTS (INPUTS)
    ) u_mux (
      .data_in  (data_in),
      .sel      (active[k*SEL +: SEL]),
      .data_out (mux_out[k])
    );
  end

  if (REG_OUT != 0) begin : g_reg_out
    always_ff @(posedge config_clk) begin
      if (config_rst)
        data_out <= '0;
      else
        data_out <= mux_out;
    end
  end else begin : g_comb_out
    assign data_out = mux_out;
  end

endmodule
